// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder
//   Receive side of a multiplexed seven-segment display. It watches the
//   active-low anode/cathode lines of a scanning driver, decodes each settled
//   digit back into a symbol code and assembles complete 8-digit frames.
//
// Ports
//   clk_in          system clock
//   rst_n_in        asynchronous active-low reset
//   cat_in[6:0]     segment lines, active-low, {g,f,e,d,c,b,a}
//   an_in[7:0]      digit selects, active-low, bit i = digit i
//   digits_out[39:0] last complete frame, digit i code at [5i+4:5i]
//   frame_valid_out one-cycle pulse when digits_out updates
//   sync_err_out    one-cycle pulse on an out-of-order digit capture
//   timeout_out     one-cycle pulse when a partial frame is abandoned
//   frame_count_out completed frame counter (wraps)
module seven_segment_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 400000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [6:0]  cat_in,
    input  logic [7:0]  an_in,
    output logic [39:0] digits_out,
    output logic        frame_valid_out,
    output logic        sync_err_out,
    output logic        timeout_out,
    output logic [15:0] frame_count_out
);

    localparam int unsigned TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    // Counter value seen in the cycle before the pulse must be issued, so the
    // pulse lands exactly TIMEOUT_CYCLES cycles after the capture cycle.
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 2);

    typedef enum logic {HUNT, COLLECT} state_t;

    logic [7:0]    r_an_s1, r_an_s2;
    logic [6:0]    r_cat_s1, r_cat_s2;
    logic [7:0]    r_prev_sel;
    logic [6:0]    r_prev_seg;
    logic [7:0]    r_stab;
    logic          r_done;
    state_t        r_state;
    logic [2:0]    r_expect;
    logic [39:0]   r_frame;
    logic [TW-1:0] r_tmo;

    logic [7:0]    w_sel;
    logic [6:0]    w_seg;
    logic          w_onehot, w_same, w_capture;
    logic [7:0]    w_stab;
    logic [2:0]    w_idx;
    logic [4:0]    w_code;

    state_t        w_state_nxt;
    logic [2:0]    w_expect_nxt;
    logic [39:0]   w_frame_nxt, w_digits_nxt;
    logic [TW-1:0] w_tmo_nxt;
    logic [15:0]   w_count_nxt;
    logic          w_fv_nxt, w_se_nxt, w_to_nxt;

    // Synchronizer preset to all-ones: nothing selected, all segments off.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_an_s1  <= '1;
            r_an_s2  <= '1;
            r_cat_s1 <= '1;
            r_cat_s2 <= '1;
        end else begin
            r_an_s1  <= an_in;
            r_an_s2  <= r_an_s1;
            r_cat_s1 <= cat_in;
            r_cat_s2 <= r_cat_s1;
        end
    end

    assign w_sel    = ~r_an_s2;
    assign w_seg    = ~r_cat_s2;
    assign w_onehot = (w_sel != '0) && ((w_sel & (w_sel - 8'd1)) == '0);
    assign w_same   = w_onehot && (w_sel == r_prev_sel) && (w_seg == r_prev_seg);

    always_comb begin
        w_stab = '0;
        if (w_same) begin
            w_stab = (r_stab == 8'hFF) ? r_stab : r_stab + 8'd1;
        end
    end

    // r_done blocks a second capture in the same dwell once the stability
    // counter has saturated.
    assign w_capture = w_onehot && (w_stab == SETTLE_LAST) && !(w_same && r_done);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_prev_sel <= '0;
            r_prev_seg <= '0;
            r_stab     <= '0;
            r_done     <= 1'b0;
        end else begin
            r_prev_sel <= w_sel;
            r_prev_seg <= w_seg;
            r_stab     <= w_stab;
            r_done     <= w_capture | (w_same & r_done);
        end
    end

    always_comb begin
        w_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (w_sel[i]) w_idx = 3'(i);
        end
    end

    always_comb begin
        case (w_seg)
            7'h3F:   w_code = 5'd0;
            7'h06:   w_code = 5'd1;
            7'h5B:   w_code = 5'd2;
            7'h4F:   w_code = 5'd3;
            7'h66:   w_code = 5'd4;
            7'h6D:   w_code = 5'd5;
            7'h7D:   w_code = 5'd6;
            7'h07:   w_code = 5'd7;
            7'h7F:   w_code = 5'd8;
            7'h6F:   w_code = 5'd9;
            7'h77:   w_code = 5'd10;
            7'h7C:   w_code = 5'd11;
            7'h39:   w_code = 5'd12;
            7'h5E:   w_code = 5'd13;
            7'h79:   w_code = 5'd14;
            7'h71:   w_code = 5'd15;
            7'h40:   w_code = 5'd16;
            7'h00:   w_code = 5'd17;
            default: w_code = 5'd31;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_expect_nxt = r_expect;
        w_frame_nxt  = r_frame;
        w_tmo_nxt    = r_tmo;
        w_digits_nxt = digits_out;
        w_count_nxt  = frame_count_out;
        w_fv_nxt     = 1'b0;
        w_se_nxt     = 1'b0;
        w_to_nxt     = 1'b0;
        case (r_state)
            HUNT: begin
                w_tmo_nxt = '0;
                if (w_capture && (w_idx == 3'd0)) begin
                    w_frame_nxt[4:0] = w_code;
                    w_expect_nxt     = 3'd1;
                    w_state_nxt      = COLLECT;
                end
            end
            COLLECT: begin
                if (w_capture) begin
                    // A capture always wins over a coincident timeout.
                    w_tmo_nxt = '0;
                    if (w_idx == r_expect) begin
                        w_frame_nxt[5*w_idx +: 5] = w_code;
                        w_expect_nxt = r_expect + 3'd1;
                        if (w_idx == 3'd7) begin
                            w_digits_nxt = {w_code, r_frame[34:0]};
                            w_fv_nxt     = 1'b1;
                            w_count_nxt  = frame_count_out + 16'd1;
                            w_state_nxt  = HUNT;
                        end
                    end else begin
                        w_se_nxt = 1'b1;
                        if (w_idx == 3'd0) begin
                            w_frame_nxt[4:0] = w_code;
                            w_expect_nxt     = 3'd1;
                        end else begin
                            w_state_nxt = HUNT;
                        end
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_to_nxt    = 1'b1;
                    w_tmo_nxt   = '0;
                    w_state_nxt = HUNT;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state         <= HUNT;
            r_expect        <= '0;
            r_frame         <= '0;
            r_tmo           <= '0;
            digits_out      <= '0;
            frame_count_out <= '0;
            frame_valid_out <= 1'b0;
            sync_err_out    <= 1'b0;
            timeout_out     <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_expect        <= w_expect_nxt;
            r_frame         <= w_frame_nxt;
            r_tmo           <= w_tmo_nxt;
            digits_out      <= w_digits_nxt;
            frame_count_out <= w_count_nxt;
            frame_valid_out <= w_fv_nxt;
            sync_err_out    <= w_se_nxt;
            timeout_out     <= w_to_nxt;
        end
    end

endmodule
